// File: rtl/priority_decoder.sv
// priority_decoder: pending-bit vector driven by SET/CLEAR/TOGGLE/FLUSH commands.
// A FLUSH drains the pending bits one per cycle, highest first, reporting each
// drained bit on onehot. Optional thermometer output enabled by the macro
// PRIORITY_DECODER_THERMO_EN (otherwise thermo is tied to zero).
module priority_decoder #(
  parameter int unsigned N = 16,
  localparam int unsigned W = (N == 1) ? 1 : $clog2(N)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         valid_in,
  output logic         ready_out,
  input  logic [1:0]   op,
  input  logic [W-1:0] index,
  output logic [N-1:0] pending,
  output logic [N-1:0] onehot,
  output logic         empty,
  output logic         done,
  output logic         error,
  output logic [N-1:0] thermo
);

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  typedef enum logic {IDLE, FLUSHING} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_d, onehot_d;
  logic         done_d, error_d;
  logic [W-1:0] top_idx;
  logic [N-1:0] top_bit;
  logic [N-1:0] sel_bit;
  logic [N-1:0] drained;
  logic         legal;
  logic         accept;

  // Ready is a direct decode of the state flop, so it follows reset immediately.
  assign ready_out = (state_q == IDLE);
  assign accept    = valid_in && ready_out;
  assign empty     = (pending == '0);
  assign legal     = (32'(index) < N);
  assign sel_bit   = N'(1) << index;
  assign top_bit   = N'(1) << top_idx;
  assign drained   = pending & ~top_bit;

  // Locate the highest set pending bit (later iterations override earlier ones).
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) top_idx = W'(i);
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending;
    onehot_d  = onehot;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_FLUSH) begin
            if (empty) done_d  = 1'b1;
            else       state_d = FLUSHING;
          end else if (!legal) begin
            error_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            case (op)
              OP_SET:    pending_d = pending | sel_bit;
              OP_CLEAR:  pending_d = pending & ~sel_bit;
              OP_TOGGLE: pending_d = pending ^ sel_bit;
              default:   pending_d = pending;
            endcase
            onehot_d = sel_bit;
            done_d   = 1'b1;
          end
        end
      end
      FLUSHING: begin
        pending_d = drained;
        onehot_d  = top_bit;
        if (drained == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      onehot  <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      pending <= pending_d;
      onehot  <= onehot_d;
      done    <= done_d;
      error   <= error_d;
    end
  end

`ifdef PRIORITY_DECODER_THERMO_EN
  logic [N-1:0] thermo_d;

  // Mask of the decoded bit and everything below it; zero until a first decode.
  assign thermo_d = (onehot_d == '0) ? '0 : (onehot_d | (onehot_d - N'(1)));

  // Thermometer register tracks onehot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) thermo <= '0;
    else          thermo <= thermo_d;
  end
`else
  assign thermo = '0;
`endif

endmodule

// File: tb/tb_priority_decoder.sv
// Testbench for priority_decoder: directed table, flush sequences, randomized
// commands against a bit-array model, reset during flush, and an N=12 build.
module tb_priority_decoder;

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  logic        clock;
  logic        reset_n;
  logic        valid_in;
  logic        ready_out;
  logic [1:0]  op;
  logic [3:0]  index;
  logic [15:0] pending, onehot, thermo;
  logic        empty, done, error;

  logic        v12, ready12, empty12, done12, error12;
  logic [1:0]  op12;
  logic [3:0]  idx12;
  logic [11:0] pend12, oh12, thermo12;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] m_pend = 16'h0;
  int          m_last = -1;

  typedef struct {
    logic [1:0]  op;
    int          idx;
    logic [15:0] pend;
    logic [15:0] oh;
  } vec_t;

  vec_t tbl[8];

  priority_decoder #(.N(16)) dut (
    .clock(clock), .reset_n(reset_n), .valid_in(valid_in), .ready_out(ready_out),
    .op(op), .index(index), .pending(pending), .onehot(onehot), .empty(empty),
    .done(done), .error(error), .thermo(thermo)
  );

  priority_decoder #(.N(12)) dut12 (
    .clock(clock), .reset_n(reset_n), .valid_in(v12), .ready_out(ready12),
    .op(op12), .index(idx12), .pending(pend12), .onehot(oh12), .empty(empty12),
    .done(done12), .error(error12), .thermo(thermo12)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_thermo();
`ifdef PRIORITY_DECODER_THERMO_EN
    if (m_last < 0) return 16'h0;
    return 16'((32'd1 << (m_last + 1)) - 32'd1);
`else
    return 16'h0;
`endif
  endfunction

  // Present a command from a negedge, wait for acceptance, return at the negedge after it.
  task automatic drive(input logic [1:0] o, input int idx);
    valid_in = 1'b1;
    op       = o;
    index    = 4'(idx);
    for (int t = 0; t < 64 && !ready_out; t++) @(negedge clock);
    if (!ready_out) check("ready_timeout", 32'(ready_out), 32'd1);
    @(posedge clock);
    @(negedge clock);
    valid_in = 1'b0;
  endtask

  // Follow a non-empty flush from the negedge after acceptance to completion.
  task automatic flush_follow();
    int q[$];
    for (int i = 15; i >= 0; i--) if (m_pend[i]) q.push_back(i);
    for (int j = 0; j < q.size(); j++) begin
      check("flush_ready_low", 32'(ready_out), 32'd0);
      if (j == 0) check("flush_no_early_done", 32'(done), 32'd0);
      @(posedge clock);
      @(negedge clock);
      m_pend[q[j]] = 1'b0;
      m_last = q[j];
      check("flush_onehot", 32'(onehot), 32'd1 << q[j]);
      check("flush_pending", 32'(pending), 32'(m_pend));
      check("flush_done", 32'(done), (j == q.size() - 1) ? 32'd1 : 32'd0);
      check("flush_thermo", 32'(thermo), 32'(exp_thermo()));
    end
    check("flush_ready_back", 32'(ready_out), 32'd1);
    check("flush_empty", 32'(empty), 32'd1);
  endtask

  // Issue one command and compare the DUT against the model.
  task automatic cmd(input logic [1:0] o, input int idx);
    drive(o, idx);
    if (o == OP_FLUSH) begin
      if (m_pend == 16'h0) begin
        check("flush0_done", 32'(done), 32'd1);
        check("flush0_ready", 32'(ready_out), 32'd1);
        check("flush0_pending", 32'(pending), 32'd0);
      end else begin
        flush_follow();
      end
    end else begin
      case (o)
        OP_SET:    m_pend[idx] = 1'b1;
        OP_CLEAR:  m_pend[idx] = 1'b0;
        default:   m_pend[idx] = ~m_pend[idx];
      endcase
      m_last = idx;
      check("cmd_pending", 32'(pending), 32'(m_pend));
      check("cmd_onehot", 32'(onehot), 32'd1 << idx);
      check("cmd_done", 32'(done), 32'd1);
      check("cmd_error", 32'(error), 32'd0);
      check("cmd_ready", 32'(ready_out), 32'd1);
      check("cmd_empty", 32'(empty), 32'(m_pend == 16'h0));
      check("cmd_thermo", 32'(thermo), 32'(exp_thermo()));
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    valid_in = 1'b0;
    op       = 2'b00;
    index    = 4'd0;
    v12      = 1'b0;
    op12     = 2'b00;
    idx12    = 4'd0;

    tbl[0] = '{OP_SET,    3,  16'h0008, 16'h0008};
    tbl[1] = '{OP_SET,    7,  16'h0088, 16'h0080};
    tbl[2] = '{OP_SET,    15, 16'h8088, 16'h8000};
    tbl[3] = '{OP_TOGGLE, 7,  16'h8008, 16'h0080};
    tbl[4] = '{OP_TOGGLE, 7,  16'h8088, 16'h0080};
    tbl[5] = '{OP_CLEAR,  3,  16'h8080, 16'h0008};
    tbl[6] = '{OP_CLEAR,  3,  16'h8080, 16'h0008};
    tbl[7] = '{OP_SET,    0,  16'h8081, 16'h0001};

    // Reset values.
    @(negedge clock);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_onehot", 32'(onehot), 32'd0);
    check("rst_thermo", 32'(thermo), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].op, tbl[i].idx);
      check("tbl_pending", 32'(pending), 32'(tbl[i].pend));
      check("tbl_onehot", 32'(onehot), 32'(tbl[i].oh));
      check("tbl_done", 32'(done), 32'd1);
      check("tbl_empty", 32'(empty), 32'd0);
      m_pend = tbl[i].pend;
      m_last = tbl[i].idx;
    end
    @(negedge clock);
    check("idle_done_drop", 32'(done), 32'd0);

    // Flush of 0x8081, then flush of an empty vector.
    cmd(OP_FLUSH, 0);
    check("flush_final_pending", 32'(pending), 32'd0);
    cmd(OP_FLUSH, 0);
    @(negedge clock);
    check("flush0_done_drop", 32'(done), 32'd0);
    check("flush0_ready_held", 32'(ready_out), 32'd1);

    // Command held during a flush is accepted only afterwards.
    cmd(OP_SET, 1);
    cmd(OP_SET, 2);
    drive(OP_FLUSH, 0);
    valid_in = 1'b1;
    op       = OP_SET;
    index    = 4'd5;
    @(posedge clock); @(negedge clock);
    check("hold_pending1", 32'(pending), 32'h0002);
    check("hold_ready1", 32'(ready_out), 32'd0);
    @(posedge clock); @(negedge clock);
    check("hold_pending2", 32'(pending), 32'h0000);
    check("hold_ready2", 32'(ready_out), 32'd1);
    check("hold_done2", 32'(done), 32'd1);
    @(posedge clock); @(negedge clock);
    valid_in = 1'b0;
    check("hold_pending3", 32'(pending), 32'h0020);
    check("hold_onehot3", 32'(onehot), 32'h0020);
    check("hold_done3", 32'(done), 32'd1);
    m_pend = 16'h0020;
    m_last = 5;

    // Randomized commands against the model.
    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 5)       cmd(OP_SET,    $urandom_range(0, 15));
      else if (r < 9)  cmd(OP_CLEAR,  $urandom_range(0, 15));
      else if (r < 14) cmd(OP_TOGGLE, $urandom_range(0, 15));
      else             cmd(OP_FLUSH,  0);
    end

    // Reset in the middle of a flush of 0xFFFF.
    cmd(OP_FLUSH, 0);
    for (int i = 0; i < 16; i++) cmd(OP_SET, i);
    drive(OP_FLUSH, 0);
    repeat (4) begin @(posedge clock); @(negedge clock); end
    check("midflush_pending", 32'(pending), 32'h0FFF);
    check("midflush_ready", 32'(ready_out), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_pending", 32'(pending), 32'd0);
    check("abort_ready", 32'(ready_out), 32'd1);
    check("abort_onehot", 32'(onehot), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_thermo", 32'(thermo), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    m_pend = 16'h0;
    m_last = -1;
    repeat (3) begin
      @(negedge clock);
      check("post_abort_done", 32'(done), 32'd0);
      check("post_abort_ready", 32'(ready_out), 32'd1);
      check("post_abort_pending", 32'(pending), 32'd0);
    end

`ifdef PRIORITY_DECODER_THERMO_EN
    cmd(OP_SET, 5);
    check("thermo_set5", 32'(thermo), 32'h003F);
`endif

    // N = 12 build: legal and illegal indices.
    v12 = 1'b1; op12 = OP_SET; idx12 = 4'd4;
    @(posedge clock); @(negedge clock);
    check("n12_set4_pending", 32'(pend12), 32'h010);
    check("n12_set4_error", 32'(error12), 32'd0);
    idx12 = 4'd13;
    @(posedge clock); @(negedge clock);
    check("n12_set13_error", 32'(error12), 32'd1);
    check("n12_set13_done", 32'(done12), 32'd1);
    check("n12_set13_pending", 32'(pend12), 32'h010);
    check("n12_set13_onehot", 32'(oh12), 32'h010);
    op12 = OP_TOGGLE; idx12 = 4'd12;
    @(posedge clock); @(negedge clock);
    v12 = 1'b0;
    check("n12_tog12_error", 32'(error12), 32'd1);
    check("n12_tog12_pending", 32'(pend12), 32'h010);
    @(negedge clock);
    check("n12_error_drop", 32'(error12), 32'd0);
    check("n12_done_drop", 32'(done12), 32'd0);
    v12 = 1'b1; op12 = OP_TOGGLE; idx12 = 4'd11;
    @(posedge clock); @(negedge clock);
    v12 = 1'b0;
    check("n12_tog11_pending", 32'(pend12), 32'h810);
    check("n12_tog11_onehot", 32'(oh12), 32'h800);
    check("n12_tog11_error", 32'(error12), 32'd0);
    check("n12_empty", 32'(empty12), 32'd0);
    check("n12_ready", 32'(ready12), 32'd1);
`ifdef PRIORITY_DECODER_THERMO_EN
    check("n12_thermo", 32'(thermo12), 32'hFFF);
`else
    check("n12_thermo", 32'(thermo12), 32'h000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
